// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule constants, state encoding and xtime
package aes_pkg;

    localparam int WORD_W = 32;
    localparam int RK_W   = 128;

    localparam logic [7:0] RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    // Multiply by x in GF(2^8) modulo the AES polynomial; advances rcon.
    function automatic logic [7:0] xtime(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// rtl/aes_sub_word.sv - four parallel AES S-box lookups on a 32-bit word
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] word_in,
    output logic [WORD_W-1:0] word_out
);

    // Forward S-box, entry 0 in the MSBs.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry b sits at bit 2047-8*b, which is {~b, 3'b111}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_byte
        assign word_out[8*k+7 -: 8] = sbox(word_in[8*k+7 -: 8]);
    end

endmodule

// File: rtl/aes_round_key_gen.sv
// rtl/aes_round_key_gen.sv - iterative AES key expansion, one schedule word per cycle
module aes_round_key_gen
    import aes_pkg::*;
#(
    parameter int NK = 4,
    parameter int NR = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [32*NK-1:0]        key_in,
    input  logic [3:0]              rk_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    keys_valid,
    output logic [RK_W-1:0]         rk_out,
    output logic [128*(NR+1)-1:0]   all_keys
);

    localparam int NW = 4 * (NR + 1);
    localparam int IW = $clog2(NW);
    localparam int WW = $clog2(NK) + 1;

    state_e              state_q, state_d;
    logic [IW-1:0]       i_q, i_d;
    logic [WW-1:0]       wrap_q, wrap_d;
    logic [7:0]          rcon_q, rcon_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                keys_valid_q, keys_valid_d;
    logic [WORD_W-1:0]   w_q [NW];
    logic [WORD_W-1:0]   w_d [NW];

    logic [IW-1:0]       i_prev;
    logic [IW-1:0]       i_back;
    logic [WORD_W-1:0]   prev_word;
    logic [WORD_W-1:0]   back_word;
    logic [WORD_W-1:0]   sub_in;
    logic [WORD_W-1:0]   sub_out;
    logic [WORD_W-1:0]   temp;
    logic [WORD_W-1:0]   new_word;

    assign i_prev    = i_q - IW'(1);
    assign i_back    = i_q - IW'(NK);
    assign prev_word = w_q[i_prev];
    assign back_word = w_q[i_back];

    // Rotation only applies on the first word of each key-length group.
    assign sub_in = (wrap_q == '0) ? {prev_word[23:0], prev_word[31:24]} : prev_word;

    aes_sub_word u_sub_word (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    // Schedule word rule; wrap_q tracks i mod NK.
    always_comb begin
        temp = prev_word;
        if (wrap_q == '0) begin
            temp = sub_out ^ {rcon_q, 24'h0};
        end else if (NK == 8 && wrap_q == WW'(4)) begin
            temp = sub_out;
        end
        new_word = back_word ^ temp;
    end

    // Next-state logic for the IDLE -> EXPAND -> DONE sequence and word storage.
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        wrap_d       = wrap_q;
        rcon_d       = rcon_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        keys_valid_d = keys_valid_q;
        w_d          = w_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    for (int j = 0; j < NK; j++) begin
                        w_d[j] = key_in[32*NK-1-32*j -: 32];
                    end
                    i_d          = IW'(NK);
                    wrap_d       = '0;
                    rcon_d       = RCON_INIT;
                    keys_valid_d = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                w_d[i_q] = new_word;
                i_d      = i_q + IW'(1);
                wrap_d   = (wrap_q == WW'(NK - 1)) ? '0 : wrap_q + WW'(1);
                if (wrap_q == '0) begin
                    rcon_d = xtime(rcon_q);
                end
                if (i_q == IW'(NW - 1)) begin
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_d       = 1'b1;
                keys_valid_d = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, flags and word storage; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            i_q          <= '0;
            wrap_q       <= '0;
            rcon_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            for (int j = 0; j < NW; j++) begin
                w_q[j] <= '0;
            end
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            wrap_q       <= wrap_d;
            rcon_q       <= rcon_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            keys_valid_q <= keys_valid_d;
            w_q          <= w_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign keys_valid = keys_valid_q;

    for (genvar g = 0; g < NW; g++) begin : g_flat
        assign all_keys[32*(NW-g)-1 -: 32] = w_q[g];
    end

    // Indexed round-key read; out-of-range indices read as zero.
    always_comb begin
        rk_out = '0;
        for (int r = 0; r <= NR; r++) begin
            if (rk_idx == 4'(r)) begin
                rk_out = {w_q[4*r], w_q[4*r+1], w_q[4*r+2], w_q[4*r+3]};
            end
        end
    end

endmodule

// File: tb/tb_aes_round_key_gen.sv
// tb/tb_aes_round_key_gen.sv - self-checking bench for aes_round_key_gen
module tb_aes_round_key_gen;

    logic          clk;
    logic          rst;

    logic          start_a;
    logic [127:0]  key_a;
    logic [3:0]    idx_a;
    logic          busy_a, done_a, kv_a;
    logic [127:0]  rk_a;
    logic [1407:0] all_a;

    logic          start_b;
    logic [255:0]  key_b;
    logic [3:0]    idx_b;
    logic          busy_b, done_b, kv_b;
    logic [127:0]  rk_b;
    logic [1919:0] all_b;

    int n_vec;
    int n_err;
    int done_cnt_a;
    int done_cnt_b;

    logic [31:0] mw [60];

    aes_round_key_gen #(.NK(4), .NR(10)) dut (
        .clk(clk), .rst(rst), .start(start_a), .key_in(key_a), .rk_idx(idx_a),
        .busy(busy_a), .done(done_a), .keys_valid(kv_a), .rk_out(rk_a), .all_keys(all_a)
    );

    aes_round_key_gen #(.NK(8), .NR(14)) dut256 (
        .clk(clk), .rst(rst), .start(start_b), .key_in(key_b), .rk_idx(idx_b),
        .busy(busy_b), .done(done_b), .keys_valid(kv_b), .rk_out(rk_b), .all_keys(all_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rst) begin
            done_cnt_a <= done_cnt_a;
        end
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // GF(2^8) arithmetic for the reference S-box.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        for (int b = 1; b < 256; b++) begin
            if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] ref_subw(input logic [31:0] w);
        return {ref_sbox(w[31:24]), ref_sbox(w[23:16]), ref_sbox(w[15:8]), ref_sbox(w[7:0])};
    endfunction

    // Key schedule straight from the word rule; key word 0 in key[255:224].
    task automatic run_model(input logic [255:0] key, input int nk);
        int nw = 4 * (nk + 7);
        logic [7:0]  rcon = 8'h01;
        logic [31:0] t;
        for (int j = 0; j < nk; j++) mw[j] = key[255-32*j -: 32];
        for (int i = nk; i < nw; i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                t = ref_subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = ref_subw(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    // Start a run on either instance; optionally pulse start again mid-run.
    task automatic go(input int nk, input logic [255:0] key, input int intrude_at,
                      input logic [255:0] other, output int lat);
        @(negedge clk);
        if (nk == 4) begin key_a = key[255:128]; start_a = 1'b1; end
        else         begin key_b = key;          start_b = 1'b1; end
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        key_a = ~key[255:128]; key_b = ~key;
        lat = 0;
        while (!((nk == 4) ? done_a : done_b) && lat < 200) begin
            if (lat == intrude_at) begin
                if (nk == 4) begin key_a = other[255:128]; start_a = 1'b1; end
                else         begin key_b = other;          start_b = 1'b1; end
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic check_sched(input int nk, input string name);
        int nr = nk + 6;
        logic [127:0] exp;
        for (int r = 0; r <= nr; r++) begin
            exp = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
            if (nk == 4) begin
                idx_a = 4'(r); #1;
                check({name, " rk_out"}, 256'(rk_a), 256'(exp));
                check({name, " all_keys"}, 256'(all_a[1407-128*r -: 128]), 256'(exp));
            end else begin
                idx_b = 4'(r); #1;
                check({name, " rk_out"}, 256'(rk_b), 256'(exp));
                check({name, " all_keys"}, 256'(all_b[1919-128*r -: 128]), 256'(exp));
            end
        end
    endtask

    typedef struct {
        logic [255:0] key;
        int           nk;
        int           w_idx;
        logic [31:0]  w_exp;
        logic [127:0] last_exp;
        int           lat_exp;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int lat;
        int dc;
        logic [255:0] rkey;
        logic [255:0] key1;
        logic [255:0] key2;

        n_vec = 0; n_err = 0; done_cnt_a = 0; done_cnt_b = 0;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        key_a = '0; key_b = '0; idx_a = '0; idx_b = '0;

        vecs[0] = '{{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 4, 32'ha0fafe17,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 41};
        vecs[1] = '{{128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, 0, 32'h00010203,
                    128'h13111d7fe3944a17f307a78b4d2b30c5, 41};
        vecs[2] = '{256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 8, 8,
                    32'h9ba35411, 128'hfe4890d1e6188d0b046df344706c631e, 53};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset busy", 256'(busy_a), 256'(0));
        check("reset done", 256'(done_a), 256'(0));
        check("reset keys_valid", 256'(kv_a), 256'(0));
        check("reset all_keys", 256'(|all_a), 256'(0));
        check("reset all_keys 256", 256'(|all_b), 256'(0));

        // Known-answer vectors.
        foreach (vecs[v]) begin
            run_model(vecs[v].key, vecs[v].nk);
            go(vecs[v].nk, vecs[v].key, -1, '0, lat);
            check("latency", 256'(lat), 256'(vecs[v].lat_exp));
            if (vecs[v].nk == 4) begin
                check("kat word", 256'(all_a[1407-32*vecs[v].w_idx -: 32]), 256'(vecs[v].w_exp));
                check("kat last", 256'(all_a[127:0]), 256'(vecs[v].last_exp));
                check("kat keys_valid", 256'(kv_a), 256'(1));
                check("kat busy", 256'(busy_a), 256'(0));
            end else begin
                check("kat word", 256'(all_b[1919-32*vecs[v].w_idx -: 32]), 256'(vecs[v].w_exp));
                check("kat last", 256'(all_b[127:0]), 256'(vecs[v].last_exp));
                check("kat keys_valid", 256'(kv_b), 256'(1));
            end
            check_sched(vecs[v].nk, "kat");
        end
        idx_a = 4'd0; #1;
        check("rk0 is key", 256'(rk_a), 256'(128'h000102030405060708090a0b0c0d0e0f));

        // Randomized keys against the model.
        for (int t = 0; t < 6; t++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if (t % 2 == 0) begin
                run_model({rkey[255:128], 128'h0}, 4);
                go(4, {rkey[255:128], 128'h0}, -1, '0, lat);
                check_sched(4, "rand128");
            end else begin
                run_model(rkey, 8);
                go(8, rkey, -1, '0, lat);
                check_sched(8, "rand256");
            end
        end

        // Second start mid-expansion is ignored.
        key1 = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        key2 = {$urandom, $urandom, $urandom, $urandom, 128'h0};
        dc = done_cnt_a;
        run_model(key1, 4);
        go(4, key1, 5, key2, lat);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("ignored start done count", 256'(done_cnt_a - dc), 256'(1));
        check("ignored start latency", 256'(lat), 256'(41));
        check_sched(4, "ignored start");

        // Reset mid-expansion aborts the run.
        dc = done_cnt_a;
        @(negedge clk);
        key_a = key2[255:128]; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("busy before abort", 256'(busy_a), 256'(1));
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", 256'(busy_a), 256'(0));
        check("abort keys_valid", 256'(kv_a), 256'(0));
        check("abort all_keys", 256'(|all_a), 256'(0));
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("abort no done", 256'(done_cnt_a - dc), 256'(0));
        run_model(key2, 4);
        go(4, key2, -1, '0, lat);
        check("after abort latency", 256'(lat), 256'(41));
        check_sched(4, "after abort");

        // Out-of-range index, then keys_valid drop on a new start.
        idx_a = 4'd11; #1;
        check("rk_idx 11", 256'(rk_a), 256'(0));
        idx_b = 4'd15; #1;
        check("rk_idx 15", 256'(rk_b), 256'(0));
        @(negedge clk);
        key_a = key1[255:128]; start_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        check("keys_valid drop", 256'(kv_a), 256'(0));
        check("busy on start", 256'(busy_a), 256'(1));
        repeat (60) @(posedge clk);
        @(negedge clk);

        // Start held high: back-to-back runs.
        dc = done_cnt_a;
        run_model(key2, 4);
        key_a = key2[255:128]; start_a = 1'b1;
        repeat (43) @(posedge clk);
        @(negedge clk);
        check("b2b second run busy", 256'(busy_a), 256'(1));
        start_a = 1'b0;
        repeat (60) @(posedge clk);
        @(negedge clk);
        check("b2b done count", 256'(done_cnt_a - dc), 256'(2));
        check("b2b keys_valid", 256'(kv_a), 256'(1));
        check_sched(4, "b2b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
